// File: rtl/regs_wr_arbiter.sv
// regs_wr_arbiter
//   Round-robin arbiter that shares the single write port of the 16x8
//   register bank between NUM_REQ writeback requesters (ALU, load unit,
//   I/O / context restore). Grants are combinational. An accepted write
//   appears on the reg_write_* port one cycle later. A saturating counter
//   records the cycles in which requesters had to contend for the port.
//
// Ports
//   clk            clock, all state on the rising edge
//   rst            asynchronous, active-high reset
//   req_valid      per-requester write request
//   req_addr       packed addresses, requester i at [i*AW +: AW]
//   req_data       packed data, requester i at [i*DW +: DW]
//   req_ready      grant, one-hot or zero (combinational)
//   wr_stall       blocks every grant in the current cycle
//   reg_write_en   registered write enable to the bank
//   reg_write_addr registered write address
//   reg_write_data registered write data
//   gnt_id         ID of the requester whose write is on the port
//   cnt_clr        synchronous clear of conflict_cnt (wins over increment)
//   conflict_cnt   saturating count of contention cycles

module regs_wr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  wr_stall,
  output logic                  reg_write_en,
  output logic [AW-1:0]         reg_write_addr,
  output logic [DW-1:0]         reg_write_data,
  output logic [1:0]            gnt_id,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      conflict_cnt
);

  logic [1:0]         rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_id;
  logic               found;
  logic [2:0]         cand;
  logic               transfer;
  logic [1:0]         next_ptr;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic [2:0]         n_valid;
  logic               contention;

  // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ. The
  // first valid one wins. Only valid, stall and pointer feed the grant,
  // so req_ready never depends on address or data.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    if (!rst && !wr_stall) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        cand = {1'b0, rr_ptr} + 3'(j);
        if (cand >= 3'(NUM_REQ)) begin
          cand = cand - 3'(NUM_REQ);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && (cand == 3'(i)) && req_valid[i]) begin
            grant[i] = 1'b1;
            grant_id = 2'(i);
            found    = 1'b1;
          end
        end
      end
    end
  end

  assign req_ready = grant;
  assign transfer  = |grant;

  // Pointer moves to the requester after the one just served.
  always_comb begin
    if (grant_id == 2'(NUM_REQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_id + 2'd1;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Contention: two or more requesters asking while the port is open.
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_valid = n_valid + 3'(req_valid[i]);
    end
    contention = !wr_stall && (n_valid >= 3'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= next_ptr;
    end
  end

  // Address, data and ID hold their last value when idle; only the
  // enable drops, so the bank sees a clean one-cycle strobe per write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_en   <= 1'b0;
      reg_write_addr <= '0;
      reg_write_data <= '0;
      gnt_id         <= '0;
    end else begin
      reg_write_en <= transfer;
      if (transfer) begin
        reg_write_addr <= sel_addr;
        reg_write_data <= sel_data;
        gnt_id         <= grant_id;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (cnt_clr) begin
      conflict_cnt <= '0;
    end else if (contention && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Directed bench for regs_wr_arbiter with hand-computed expectations.

module tb_regs_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [11:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_stall;
  logic        reg_write_en;
  logic [3:0]  reg_write_addr;
  logic [7:0]  reg_write_data;
  logic [1:0]  gnt_id;
  logic        cnt_clr;
  logic [7:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  regs_wr_arbiter #(.NUM_REQ(3), .AW(4), .DW(8), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .wr_stall       (wr_stall),
    .reg_write_en   (reg_write_en),
    .reg_write_addr (reg_write_addr),
    .reg_write_data (reg_write_data),
    .gnt_id         (gnt_id),
    .cnt_clr        (cnt_clr),
    .conflict_cnt   (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 3'b000;
    req_addr  = {4'd7, 4'd6, 4'd5};
    req_data  = {8'h12, 8'h11, 8'h10};
    wr_stall  = 1'b0;
    cnt_clr   = 1'b0;

    // Reset state; ready stays low under reset even with requests.
    step();
    req_valid = 3'b111;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_en",    32'(reg_write_en), 32'h0);
    check("rst_addr",  32'(reg_write_addr), 32'h0);
    check("rst_data",  32'(reg_write_data), 32'h0);
    check("rst_gnt",   32'(gnt_id), 32'h0);
    check("rst_cnt",   32'(conflict_cnt), 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 3'b000;

    // Single write from requester 0.
    req_addr  = {4'd7, 4'd6, 4'd3};
    req_data  = {8'h12, 8'h11, 8'hA5};
    req_valid = 3'b001;
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 3'b000;
    check("t1_en",   32'(reg_write_en), 32'h1);
    check("t1_addr", 32'(reg_write_addr), 32'h3);
    check("t1_data", 32'(reg_write_data), 32'hA5);
    check("t1_gnt",  32'(gnt_id), 32'h0);
    step();
    check("t1_en_off",   32'(reg_write_en), 32'h0);
    check("t1_addr_hold", 32'(reg_write_addr), 32'h3);

    // All three valid for 6 cycles; pointer sits at 1 -> order 1,2,0,1,2,0.
    req_addr  = {4'd7, 4'd6, 4'd5};
    req_data  = {8'h12, 8'h11, 8'h10};
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      int k;
      k = (1 + c) % 3;
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << k));
      step();
      check("rr_en",   32'(reg_write_en), 32'h1);
      check("rr_gnt",  32'(gnt_id), 32'(k));
      check("rr_addr", 32'(reg_write_addr), 32'(k + 5));
      check("rr_data", 32'(reg_write_data), 32'(8'h10 + k));
    end
    check("rr_cnt", 32'(conflict_cnt), 32'd6);
    req_valid = 3'b000;

    // Move pointer to 0 via requester 2, then 110 -> 1 then 2.
    req_valid = 3'b100;
    #1;
    check("p_ready2", 32'(req_ready), 32'h4);
    step();
    check("p_gnt2", 32'(gnt_id), 32'h2);
    req_valid = 3'b110;
    #1;
    check("m_ready1", 32'(req_ready), 32'h2);
    step();
    check("m_gnt1", 32'(gnt_id), 32'h1);
    check("m_ready2", 32'(req_ready), 32'h4);
    step();
    check("m_gnt2", 32'(gnt_id), 32'h2);
    check("m_ready1b", 32'(req_ready), 32'h2);
    check("m_cnt", 32'(conflict_cnt), 32'd8);
    req_valid = 3'b000;

    // Stall: write accepted before stall still appears; nothing moves.
    req_valid = 3'b111;
    #1;
    check("s_ready0", 32'(req_ready), 32'h1);
    step();
    wr_stall = 1'b1;
    #1;
    check("s_inflight", 32'(reg_write_en), 32'h1);
    check("s_ready_off", 32'(req_ready), 32'h0);
    step();
    check("s_en_off", 32'(reg_write_en), 32'h0);
    check("s_ready_off2", 32'(req_ready), 32'h0);
    step();
    step();
    check("s_en_off3", 32'(reg_write_en), 32'h0);
    check("s_cnt_hold", 32'(conflict_cnt), 32'd9);
    wr_stall = 1'b0;
    #1;
    check("s_resume", 32'(req_ready), 32'h2);
    step();
    check("s_gnt1", 32'(gnt_id), 32'h1);
    check("s_cnt", 32'(conflict_cnt), 32'd10);
    req_valid = 3'b000;

    // Saturation: 10 + 244 = 254, +1 = 255, then holds.
    req_valid = 3'b011;
    for (int c = 0; c < 244; c++) step();
    check("sat_254", 32'(conflict_cnt), 32'd254);
    step();
    check("sat_255", 32'(conflict_cnt), 32'd255);
    for (int c = 0; c < 55; c++) step();
    check("sat_hold", 32'(conflict_cnt), 32'd255);
    cnt_clr = 1'b1;
    step();
    check("clr", 32'(conflict_cnt), 32'd0);
    cnt_clr = 1'b0;
    step();
    check("clr_inc", 32'(conflict_cnt), 32'd1);
    req_valid = 3'b000;

    // Reset mid-operation drops the in-flight write.
    req_valid = 3'b111;
    step();
    check("r_en_before", 32'(reg_write_en), 32'h1);
    #4;
    rst = 1'b1;
    #1;
    check("r_en",    32'(reg_write_en), 32'h0);
    check("r_addr",  32'(reg_write_addr), 32'h0);
    check("r_data",  32'(reg_write_data), 32'h0);
    check("r_cnt",   32'(conflict_cnt), 32'h0);
    check("r_ready", 32'(req_ready), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("r_prio0", 32'(req_ready), 32'h1);
    step();
    check("r_gnt0", 32'(gnt_id), 32'h0);
    check("r_en_after", 32'(reg_write_en), 32'h1);
    req_valid = 3'b000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs_wr_arbiter.md
Name: regs_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the 16x8 register bank (regs_16x8) between NUM_REQ writeback requesters. Typical requesters are ALU writeback (req 0), load unit (req 1) and I/O/interrupt context restore (req 2). Accepted writes are registered and driven onto reg_write_en/addr/data one cycle later. A global stall input blocks all grants. A saturating counter records contention cycles for debug.

Parameters:
NUM_REQ, 3, number of requesters (2..4 supported; ID width fixed at 2 bits)
AW, 4, register address width
DW, 8, register data width
CNT_W, 8, contention counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester write request
req_addr  in  NUM_REQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
req_data  in  NUM_REQ*DW  packed data; requester i uses bits [i*DW +: DW]
req_ready  out  NUM_REQ  combinational grant, one-hot or zero
wr_stall  in  1  when 1, no requester is granted this cycle
reg_write_en  out  1  to regs_16x8 write enable (registered)
reg_write_addr  out  AW  to regs_16x8 write address (registered)
reg_write_data  out  DW  to regs_16x8 write data (registered)
gnt_id  out  2  ID of the requester whose write is currently on the port (registered)
cnt_clr  in  1  synchronous clear of the contention counter
conflict_cnt  out  CNT_W  saturating count of contention cycles

Behaviour:
- Reset (async, rst=1):
  - reg_write_en=0, reg_write_addr=0, reg_write_data=0, gnt_id=0, conflict_cnt=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is forced to 0 while rst=1.
- Handshake:
  - A transfer from requester i occurs on a rising edge where req_valid[i] && req_ready[i].
  - Requesters hold valid, addr and data stable until accepted. Dropping valid before acceptance is legal; the request is simply withdrawn.
- Grant selection (combinational):
  - If wr_stall=1 or no valid request: req_ready=0.
  - Otherwise grant the first valid requester scanning i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Exactly one req_ready bit is set.
  - req_ready depends only on req_valid, wr_stall and rr_ptr, never on addr or data.
- Pointer update:
  - On a transfer by requester k: rr_ptr <= (k+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
  - Guarantees no requester waits more than NUM_REQ-1 grants.
- Write port (1-cycle latency):
  - On the edge of a transfer by k: reg_write_en<=1, reg_write_addr<=addr_k, reg_write_data<=data_k, gnt_id<=k.
  - With no transfer: reg_write_en<=0. addr, data and gnt_id hold their last values.
  - The bank captures the data on the following edge. Readers see the new value two edges after acceptance.
  - Back-to-back grants produce one write per cycle, full throughput.
- Same-address writes in consecutive cycles are issued in grant order; the later grant wins. No merging and no hazard detection.
- Contention counter:
  - Increments by 1 on each edge where wr_stall=0 and two or more req_valid bits are 1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 forces 0 and takes priority over increment.
- wr_stall:
  - Asserted in cycle t: no transfer in cycle t, and reg_write_en=0 in cycle t+1.
  - A write accepted in cycle t-1 still appears in cycle t; stall does not cancel it.
- Reset mid-operation: an in-flight write (reg_write_en=1) is dropped immediately; pending requests are not remembered.
- Requesters with index >= NUM_REQ do not exist. gnt_id upper values are unused when NUM_REQ<4.

Test Plan:
- Reset, then req_valid=001, addr0=3, data0=0xA5 -> req_ready=001 same cycle; next cycle reg_write_en=1, addr=3, data=0xA5, gnt_id=0; following cycle reg_write_en=0.
- All three valid, held continuously for 6 cycles, rr_ptr=0 -> grant order 0,1,2,0,1,2; reg_write_en=1 for 6 consecutive cycles; conflict_cnt increments every cycle there are >=2 valids.
- req_valid=110 with rr_ptr=0 -> req 1 granted; pointer becomes 2; req 2 is granted next cycle before req 1 repeats.
- wr_stall=1 for 3 cycles with all valid -> req_ready=000; reg_write_en=0 one cycle after stall starts; rr_ptr and conflict_cnt unchanged. On release, grant resumes at the saved pointer.
- Contention held 300 cycles with CNT_W=8 -> conflict_cnt=255 and holds; cnt_clr pulsed together with contention -> 0 the next cycle.
- Transfer at cycle t, rst asserted at t+0.5 -> reg_write_en=0 and all outputs 0 immediately; after release, rr_ptr=0 and requester 0 has priority.
